am9513_ctx_xfer: RTL and testbench

AM9513_CTX_XFER -- requirements
Module: am9513_ctx_xfer

---
 rtl/am9513_ctx_xfer.sv | 157 +++++++++++++++
 tb/tb_am9513_ctx_xfer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am9513_ctx_xfer.sv
// Context save/restore engine: streams one context's rounding mode, flags and
// 16 registers out of the context file, or writes them back from a stream.
module am9513_ctx_xfer #(
  parameter int NUM_CONTEXTS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [15:0] cmd_ctx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  output logic        done,
  output logic        err_ctx,
  output logic        err_frame,
  output logic        busy,
  output logic [15:0] cf_ctx_sel,
  output logic [3:0]  cf_rf_index,
  input  logic [1:0]  cf_rm_rdata,
  input  logic [4:0]  cf_flags_rdata,
  input  logic [63:0] cf_rf_rdata,
  output logic        cf_rm_we,
  output logic [1:0]  cf_rm_wdata,
  output logic        cf_flags_clr_we,
  output logic [4:0]  cf_flags_clr_mask,
  output logic        cf_flags_or_we,
  output logic [4:0]  cf_flags_or_mask,
  output logic        cf_rf_we,
  output logic [63:0] cf_rf_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SAVE, S_R_HDR, S_R_FLG, S_R_RF, S_DONE
  } state_t;

  // 17 bits so that NUM_CONTEXTS = 65536 still compares correctly
  localparam logic [16:0] CTX_LIMIT = 17'(NUM_CONTEXTS);

  state_t      state, state_nxt;
  logic [15:0] ctx_q;
  logic [4:0]  bcnt;
  logic [4:0]  flags_q;
  logic        err_ctx_q, err_frame_q;
  logic        ctx_bad, last_beat;

  assign ctx_bad     = {1'b0, cmd_ctx} >= CTX_LIMIT;
  assign last_beat   = (bcnt == 5'd16);
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign cf_ctx_sel  = busy ? ctx_q : 16'd0;
  assign cf_rf_index = 4'(bcnt - 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ctx_q       <= 16'd0;
      bcnt        <= 5'd0;
      flags_q     <= 5'd0;
      err_ctx_q   <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (cmd_valid) begin
          ctx_q       <= cmd_ctx;
          bcnt        <= 5'd0;
          err_ctx_q   <= ctx_bad;
          err_frame_q <= 1'b0;
        end
        S_SAVE: if (out_ready) bcnt <= bcnt + 5'd1;
        S_R_HDR: if (in_valid) begin
          flags_q <= in_data[6:2];
          bcnt    <= 5'd1;
          if (in_last) err_frame_q <= 1'b1;
        end
        S_R_RF: if (in_valid) begin
          bcnt <= bcnt + 5'd1;
          // last must coincide with the 16th register beat, no earlier or later
          if (last_beat ? !in_last : in_last) err_frame_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = ctx_bad ? S_DONE : (cmd_op ? S_R_HDR : S_SAVE);
      S_SAVE:  if (out_ready && last_beat) state_nxt = S_DONE;
      S_R_HDR: if (in_valid) state_nxt = in_last ? S_DONE : S_R_FLG;
      S_R_FLG: state_nxt = S_R_RF;
      S_R_RF:  if (in_valid && (last_beat || in_last)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid         = 1'b0;
    out_last          = 1'b0;
    out_data          = 64'd0;
    in_ready          = 1'b0;
    done              = 1'b0;
    err_ctx           = 1'b0;
    err_frame         = 1'b0;
    cf_rm_we          = 1'b0;
    cf_rm_wdata       = 2'd0;
    cf_flags_clr_we   = 1'b0;
    cf_flags_clr_mask = 5'd0;
    cf_flags_or_we    = 1'b0;
    cf_flags_or_mask  = 5'd0;
    cf_rf_we          = 1'b0;
    cf_rf_wdata       = 64'd0;
    case (state)
      S_SAVE: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        out_data  = (bcnt == 5'd0) ? {57'd0, cf_flags_rdata, cf_rm_rdata} : cf_rf_rdata;
      end
      S_R_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cf_rm_we          = 1'b1;
          cf_rm_wdata       = in_data[1:0];
          cf_flags_clr_we   = 1'b1;
          cf_flags_clr_mask = 5'h1F;
        end
      end
      S_R_FLG: begin
        cf_flags_or_we   = 1'b1;
        cf_flags_or_mask = flags_q;
      end
      S_R_RF: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cf_rf_we    = 1'b1;
          cf_rf_wdata = in_data;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        err_ctx   = err_ctx_q;
        err_frame = err_frame_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_am9513_ctx_xfer.sv
// Bench for am9513_ctx_xfer: a behavioural context file plus a shadow model
// of what the file and the save stream must contain after each command.
module tb_am9513_ctx_xfer;
  localparam int NC = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_op;
  logic [15:0] cmd_ctx;
  logic        cmd_ready;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic        in_valid, in_ready, in_last;
  logic [63:0] in_data;
  logic        done, err_ctx, err_frame, busy;
  logic [15:0] cf_ctx_sel;
  logic [3:0]  cf_rf_index;
  logic [1:0]  cf_rm_rdata;
  logic [4:0]  cf_flags_rdata;
  logic [63:0] cf_rf_rdata;
  logic        cf_rm_we, cf_flags_clr_we, cf_flags_or_we, cf_rf_we;
  logic [1:0]  cf_rm_wdata;
  logic [4:0]  cf_flags_clr_mask, cf_flags_or_mask;
  logic [63:0] cf_rf_wdata;

  always #5 clk = ~clk;

  am9513_ctx_xfer #(.NUM_CONTEXTS(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ctx(cmd_ctx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .done(done), .err_ctx(err_ctx), .err_frame(err_frame), .busy(busy),
    .cf_ctx_sel(cf_ctx_sel), .cf_rf_index(cf_rf_index),
    .cf_rm_rdata(cf_rm_rdata), .cf_flags_rdata(cf_flags_rdata), .cf_rf_rdata(cf_rf_rdata),
    .cf_rm_we(cf_rm_we), .cf_rm_wdata(cf_rm_wdata),
    .cf_flags_clr_we(cf_flags_clr_we), .cf_flags_clr_mask(cf_flags_clr_mask),
    .cf_flags_or_we(cf_flags_or_we), .cf_flags_or_mask(cf_flags_or_mask),
    .cf_rf_we(cf_rf_we), .cf_rf_wdata(cf_rf_wdata)
  );

  // context file seen by the DUT
  logic [1:0]  mem_rm    [NC];
  logic [4:0]  mem_flags [NC];
  logic [63:0] mem_rf    [NC][16];
  logic        mem_init;
  // shadow model of what the context file must hold
  logic [1:0]  exp_rm    [NC];
  logic [4:0]  exp_flags [NC];
  logic [63:0] exp_rf    [NC][16];

  assign cf_rm_rdata    = mem_rm[cf_ctx_sel[5:0]];
  assign cf_flags_rdata = mem_flags[cf_ctx_sel[5:0]];
  assign cf_rf_rdata    = mem_rf[cf_ctx_sel[5:0]][cf_rf_index];

  function automatic logic [63:0] init_rf(input int c, input int i);
    return 64'hA000_0000_0000_0000 | (64'(c) << 8) | 64'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int c = 0; c < NC; c++) begin
        mem_rm[c]    <= 2'(c);
        mem_flags[c] <= 5'(c) ^ 5'h0A;
        for (int i = 0; i < 16; i++) mem_rf[c][i] <= init_rf(c, i);
      end
    end else begin
      if (cf_rm_we) mem_rm[cf_ctx_sel[5:0]] <= cf_rm_wdata;
      if (cf_flags_clr_we)
        mem_flags[cf_ctx_sel[5:0]] <= mem_flags[cf_ctx_sel[5:0]] & ~cf_flags_clr_mask;
      else if (cf_flags_or_we)
        mem_flags[cf_ctx_sel[5:0]] <= mem_flags[cf_ctx_sel[5:0]] | cf_flags_or_mask;
      if (cf_rf_we) mem_rf[cf_ctx_sel[5:0]][cf_rf_index] <= cf_rf_wdata;
    end
  end

  int checks = 0, passes = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor state shared with the main process
  logic [64:0] exp_q[$];
  logic [63:0] obs[17];
  logic [15:0] cur_ctx = 16'd0;
  logic        exp_err_ctx = 1'b0, exp_err_frame = 1'b0;
  int          nbeats = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0, done_cyc = 0;

  initial begin : monitor
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        any_we, inv_ok;
    logic [64:0] e;
    prev_stall = 1'b0;
    prev_data  = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        any_we = cf_rm_we | cf_flags_clr_we | cf_flags_or_we | cf_rf_we;
        inv_ok = (cmd_ready == !busy) && (done || (!err_ctx && !err_frame)) &&
                 (busy ? (cf_ctx_sel == cur_ctx)
                       : (cf_ctx_sel == 16'd0 && !out_valid && !in_ready && !any_we && !done));
        chk("cycle_invariants", 64'(inv_ok), 64'd1);
        if (prev_stall && out_valid) chk("stall_hold", out_data, prev_data);
        if (out_valid && out_ready) begin
          chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", out_data, e[63:0]);
            chk("beat_last", 64'(out_last), 64'(e[64]));
          end
          if (nbeats == 0) first_cyc = cyc;
          if (nbeats < 17) obs[nbeats] = out_data;
          nbeats++;
          last_cyc = cyc;
        end
        if (done) begin
          chk("done_err_ctx", 64'(err_ctx), 64'(exp_err_ctx));
          chk("done_err_frame", 64'(err_frame), 64'(exp_err_frame));
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic issue(input logic op, input logic [15:0] ctx, output int acc);
    bit ok = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_ctx = ctx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = cyc; ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input int start, input bit toggle);
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != start) break;
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("done_once", 64'(done_cnt - start), 64'd1);
  endtask

  task automatic cmp_mem(input string name);
    int bad = 0;
    for (int c = 0; c < NC; c++) begin
      if (mem_rm[c] !== exp_rm[c]) bad++;
      if (mem_flags[c] !== exp_flags[c]) bad++;
      for (int i = 0; i < 16; i++) if (mem_rf[c][i] !== exp_rf[c][i]) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic load_save_model(input logic [15:0] ctx);
    exp_q.delete();
    nbeats = 0;
    cur_ctx = ctx;
    exp_err_ctx = (ctx >= 16'(NC));
    exp_err_frame = 1'b0;
    if (ctx < 16'(NC)) begin
      exp_q.push_back({1'b0, 57'd0, exp_flags[ctx[5:0]], exp_rm[ctx[5:0]]});
      for (int k = 1; k <= 16; k++) exp_q.push_back({(k == 16), exp_rf[ctx[5:0]][k-1]});
    end
  endtask

  task automatic run_save(input logic [15:0] ctx, input bit toggle, output int acc);
    int start;
    load_save_model(ctx);
    start = done_cnt;
    out_ready = 1'b1;
    issue(1'b0, ctx, acc);
    wait_done(start, toggle);
    out_ready = 1'b0;
    chk("save_beats", 64'(nbeats), (ctx < 16'(NC)) ? 64'd17 : 64'd0);
    chk("save_queue_drained", 64'(exp_q.size()), 64'd0);
    if (ctx < 16'(NC)) chk("save_done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    else chk("ctx_err_done_lat", 64'(done_cyc), 64'(acc + 1));
    cmp_mem("save_mem_untouched");
  endtask

  // last_beat: beat index carrying in_last (16 = normal end); last16 selects
  // whether beat 16 actually carries in_last
  task automatic run_restore(input logic [15:0] ctx, input logic [63:0] hdr,
                             input logic [63:0] base, input int last_beat,
                             input bit last16, input bit gaps, output int acc);
    int  start;
    bit  bad, got;
    bad = (ctx >= 16'(NC));
    exp_q.delete();
    nbeats = 0;
    cur_ctx = ctx;
    exp_err_ctx = bad;
    exp_err_frame = !bad && (last_beat < 16 || !last16);
    if (!bad) begin
      exp_rm[ctx[5:0]]    = hdr[1:0];
      exp_flags[ctx[5:0]] = (last_beat == 0) ? 5'd0 : hdr[6:2];
      for (int i = 0; i < last_beat; i++) exp_rf[ctx[5:0]][i] = base + 64'(i);
    end
    start = done_cnt;
    issue(1'b1, ctx, acc);
    if (!bad) begin
      for (int b = 0; b <= last_beat; b++) begin
        if (gaps && (b % 4 == 2)) begin in_valid = 1'b0; @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = (b == 0) ? hdr : base + 64'(b - 1);
        in_last  = (b == last_beat) && (b < 16 || last16);
        got = 0;
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (in_ready) begin got = 1; break; end
        end
        @(posedge clk); #1;
        chk("in_beat_accept", 64'(got), 64'd1);
        if (!got) break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 64'd0;
    wait_done(start, 1'b0);
    if (bad) chk("ctx_err_done_lat", 64'(done_cyc), 64'(acc + 1));
    cmp_mem("restore_mem");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end

  initial begin : main
    int acc, start;
    rst_n = 1'b0; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ctx = 16'd0;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 64'd0;
    for (int c = 0; c < NC; c++) begin
      exp_rm[c]    = 2'(c);
      exp_flags[c] = 5'(c) ^ 5'h0A;
      for (int i = 0; i < 16; i++) exp_rf[c][i] = init_rf(c, i);
    end
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_err", 64'({done, err_ctx, err_frame}), 64'd0);
    chk("rst_stream", 64'({out_valid, in_ready}), 64'd0);
    chk("rst_we", 64'({cf_rm_we, cf_flags_clr_we, cf_flags_or_we, cf_rf_we}), 64'd0);
    chk("rst_ctx_sel", 64'(cf_ctx_sel), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full-rate save of ctx 3
    run_save(16'd3, 1'b0, acc);
    chk("save3_first_beat_lat", 64'(first_cyc), 64'(acc + 1));
    chk("save3_last_beat_cyc", 64'(last_cyc), 64'(acc + 17));
    chk("save3_beat0_literal", obs[0], 64'h27);
    chk("save3_beat5_literal", obs[5], 64'hA000_0000_0000_0304);

    // save with out_ready toggling every cycle
    run_save(16'd10, 1'b1, acc);

    // clean restore of ctx 7, with some in_valid gaps
    run_restore(16'd7, 64'h5D, 64'h100, 16, 1'b1, 1'b1, acc);
    chk("rest7_rm_literal", 64'(mem_rm[7]), 64'd1);
    chk("rest7_flags_literal", 64'(mem_flags[7]), 64'h17);
    chk("rest7_rf0_literal", mem_rf[7][0], 64'h100);
    chk("rest7_rf15_literal", mem_rf[7][15], 64'h10F);

    // read the restored context back out
    run_save(16'd7, 1'b0, acc);
    chk("save7_beat0_literal", obs[0], 64'h5D);

    // out-of-range context ids
    run_save(16'd64, 1'b0, acc);
    run_restore(16'hFFFF, 64'h7F, 64'h0, 16, 1'b1, 1'b0, acc);

    // in_last on the fourth beat of the stream (register beat 3)
    run_restore(16'd5, 64'h26, 64'h200, 3, 1'b1, 1'b0, acc);
    chk("rest5_rf2_literal", mem_rf[5][2], 64'h202);
    chk("rest5_rf3_untouched", mem_rf[5][3], 64'hA000_0000_0000_0503);

    // stream runs the full length but never marks its last beat
    run_restore(16'd9, 64'h0B, 64'h900, 16, 1'b0, 1'b0, acc);
    // in_last already on the header
    run_restore(16'd2, 64'h7E, 64'h0, 0, 1'b1, 1'b0, acc);
    chk("rest2_flags_cleared", 64'(mem_flags[2]), 64'd0);
    chk("rest2_rm_literal", 64'(mem_rm[2]), 64'd2);

    // reset while beat 8 of a save is being offered
    load_save_model(16'd3);
    start = done_cnt;
    out_ready = 1'b1;
    issue(1'b0, 16'd3, acc);
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_beats_sent", 64'(nbeats), 64'd8);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_idle", 64'({busy, cmd_ready}), 64'b01);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", 64'(done_cnt - start), 64'd0);
    exp_q.delete();

    run_save(16'd12, 1'b0, acc);
    chk("after_abort_beat0", obs[0], {57'd0, 5'h06, 2'd0});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
